binary_to_bcd_iterative: RTL

BINARY_TO_BCD_ITERATIVE -- requirements
Module: binary_to_bcd_iterative

---
 rtl/bcd_pkg.sv | 32 +++
 rtl/bcd_digit_adjust.sv | 24 ++
 rtl/binary_to_bcd_iterative.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/bcd_pkg.sv
`default_nettype none
// ============================================================================
//  Module : bcd_pkg
//  Brief  : Shared types and constants for the iterative binary-to-BCD
//           converter: FSM state encoding, BCD digit width and a power-of-ten
//           helper used for the overflow limit.
//  Rev    : 1.0  initial release
// ============================================================================
package bcd_pkg;

  // Width of one packed BCD digit.
  localparam int BCD_DIGIT_W = 4;

  // Converter control states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // 10^n as a 64-bit constant; 10^10 still fits comfortably.
  function automatic logic [63:0] pow10(input int n);
    logic [63:0] p;
    p = 64'd1;
    for (int i = 0; i < n; i++) begin
      p = p * 64'd10;
    end
    return p;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_digit_adjust.sv
`default_nettype none
// ============================================================================
//  Module : bcd_digit_adjust
//  Brief  : Double-dabble correction for a single BCD digit: digits above 4
//           get 3 added so the following left shift carries correctly.
//  Rev    : 1.0  initial release
// ============================================================================
module bcd_digit_adjust
  import bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] digit_in,
  output logic [BCD_DIGIT_W-1:0] digit_out
);

  // Add-3 correction when the digit would reach 10 or more after doubling.
  always_comb begin
    digit_out = digit_in;
    if (digit_in > 4'd4) begin
      digit_out = digit_in + 4'd3;
    end
  end

endmodule
`default_nettype wire

// File: rtl/binary_to_bcd_iterative.sv
`default_nettype none
// ============================================================================
//  Module : binary_to_bcd_iterative
//  Brief  : Sequential shift-and-add-3 binary to packed BCD converter with
//           leading-zero blank mask and overflow flag. One input bit is
//           consumed per clock.
//  Rev    : 1.0  initial release
// ============================================================================
module binary_to_bcd_iterative
  import bcd_pkg::*;
#(
  parameter int BIN_WIDTH = 8,
  parameter int DIGITS    = 3
)(
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            start,
  input  logic [BIN_WIDTH-1:0]            bin,
  output logic                            busy,
  output logic                            done,
  output logic [BCD_DIGIT_W*DIGITS-1:0]   bcd,
  output logic [DIGITS-1:0]               blank,
  output logic                            overflow
);

  localparam int                SCR_W     = BCD_DIGIT_W * DIGITS;
  localparam int                CNT_W     = $clog2(BIN_WIDTH + 1);
  localparam logic [63:0]       LIMIT     = pow10(DIGITS);
  // Every digit except digit 0 is a leading zero when the value is zero.
  localparam logic [DIGITS-1:0] BLANK_RST = {DIGITS{1'b1}} << 1;

  generate
    if (BIN_WIDTH < 1 || BIN_WIDTH > 32 || DIGITS < 1 || DIGITS > 10) begin : g_param_check
      $error("binary_to_bcd_iterative: BIN_WIDTH must be 1..32 and DIGITS 1..10");
    end
  endgenerate

  state_t                 state;
  state_t                 state_next;
  logic [BIN_WIDTH-1:0]   shreg;
  logic [SCR_W-1:0]       scratch;
  logic [SCR_W-1:0]       scratch_adj;
  logic [CNT_W-1:0]       count;
  logic                   ovf_pending;
  logic [DIGITS-1:0]      blank_next;

  // One add-3 corrector per scratch digit.
  for (genvar g = 0; g < DIGITS; g++) begin : g_digit_adjust
    bcd_digit_adjust u_adjust (
      .digit_in  (scratch[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .digit_out (scratch_adj[g*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end

  // FSM state register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic and status outputs. SHIFT keeps going one cycle after the
  // last shift (count at zero) so DONE is entered with a settled scratch value.
  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        busy = 1'b1;
        if (count == '0) begin
          state_next = DONE;
        end
      end
      DONE: begin
        busy       = 1'b1;
        done       = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Datapath: capture operand on accepted start, then one double-dabble step per cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      shreg       <= '0;
      scratch     <= '0;
      count       <= '0;
      ovf_pending <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            shreg       <= bin;
            scratch     <= '0;
            count       <= CNT_W'(BIN_WIDTH);
            ovf_pending <= (64'(bin) >= LIMIT);
          end
        end
        SHIFT: begin
          if (count != '0) begin
            // Carries out of the top digit are dropped: result is value mod 10^DIGITS.
            scratch <= {scratch_adj[SCR_W-2:0], shreg[BIN_WIDTH-1]};
            shreg   <= shreg << 1;
            count   <= count - CNT_W'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Leading-zero mask: digit i blanks when it and every digit above it are zero.
  always_comb begin
    logic upper_zero;
    upper_zero = 1'b1;
    blank_next = '0;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      upper_zero    = upper_zero & (scratch[i*BCD_DIGIT_W +: BCD_DIGIT_W] == '0);
      blank_next[i] = upper_zero;
    end
  end

  // Result registers update together on entry to DONE and hold otherwise.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bcd      <= '0;
      blank    <= BLANK_RST;
      overflow <= 1'b0;
    end else if (state == SHIFT && state_next == DONE) begin
      bcd      <= scratch;
      blank    <= blank_next;
      overflow <= ovf_pending;
    end
  end

endmodule
`default_nettype wire
